// File: rtl/iter_round_ctrl_pkg.sv
// Shared constants and types for the iterative round controller.
package iter_round_ctrl_pkg;

  // Default widths of the round counter and the engine watchdog.
  localparam int CNT_W_DEF = 4;
  localparam int TO_W_DEF  = 6;

  // One-hot bit position of each controller state.
  localparam int ST_IDLE    = 0;
  localparam int ST_FETCH   = 1;
  localparam int ST_LOAD    = 2;
  localparam int ST_PREP    = 3;
  localparam int ST_KICK    = 4;
  localparam int ST_WAIT    = 5;
  localparam int ST_UPDATE  = 6;
  localparam int ST_NEXT    = 7;
  localparam int ST_DONE    = 8;
  localparam int NUM_STATES = 9;

  // Source select for the A/B/C/D working registers.
  localparam logic UPD_SEL_INIT  = 1'b0;
  localparam logic UPD_SEL_ROUND = 1'b1;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE   = NUM_STATES'(1) << ST_IDLE,
    S_FETCH  = NUM_STATES'(1) << ST_FETCH,
    S_LOAD   = NUM_STATES'(1) << ST_LOAD,
    S_PREP   = NUM_STATES'(1) << ST_PREP,
    S_KICK   = NUM_STATES'(1) << ST_KICK,
    S_WAIT   = NUM_STATES'(1) << ST_WAIT,
    S_UPDATE = NUM_STATES'(1) << ST_UPDATE,
    S_NEXT   = NUM_STATES'(1) << ST_NEXT,
    S_DONE   = NUM_STATES'(1) << ST_DONE
  } state_t;

  // Moore outputs driven by the controller, registered as one bundle.
  typedef struct packed {
    logic mem_en;
    logic regs_en;
    logic f_en;
    logic sel;
    logic upd_sel;
    logic rnd_start;
    logic cnt_en;
    logic busy;
    logic done;
  } ctrl_out_t;

  // Output decode for a given state; everything not listed stays low.
  function automatic ctrl_out_t decode_state(input state_t s);
    ctrl_out_t o;
    o      = '0;
    o.busy = (s != S_IDLE);
    case (s)
      S_FETCH: o.mem_en = 1'b1;
      S_LOAD: begin
        o.regs_en = 1'b1;
        o.upd_sel = UPD_SEL_INIT;
      end
      S_PREP: begin
        o.sel  = 1'b1;
        o.f_en = 1'b1;
      end
      S_KICK: o.rnd_start = 1'b1;
      S_UPDATE: begin
        o.regs_en = 1'b1;
        o.mem_en  = 1'b1;
        o.f_en    = 1'b1;
        o.sel     = 1'b0;
        o.upd_sel = UPD_SEL_ROUND;
      end
      S_NEXT: o.cnt_en = 1'b1;
      S_DONE: o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/iter_round_ctrl_round_counter.sv
// Round index counter with clear, advance and a last-round compare.
module round_counter
  import iter_round_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] bound,
  output logic [CNT_W-1:0] idx,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] idx_q, idx_d;

  // Clear wins over advance; the controller never advances past the bound.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = idx_q + CNT_ONE;
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == (bound - CNT_ONE));

endmodule

// File: rtl/iter_round_ctrl.sv
// One-hot sequencer: fetch, load, then N rounds through an external engine.
module iter_round_ctrl
  import iter_round_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TO_W  = TO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rounds,
  input  logic             abort,
  input  logic             rnd_done,
  output logic             mem_en,
  output logic             regs_en,
  output logic             f_en,
  output logic             sel,
  output logic             upd_sel,
  output logic             rnd_start,
  output logic             cnt_en,
  output logic [CNT_W-1:0] round_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [TO_W-1:0] WD_ONE = TO_W'(1);
  // One below all-ones: the cycle whose increment makes the watchdog all-ones.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t           state_q, state_d;
  ctrl_out_t        out_q, out_d;
  logic [CNT_W-1:0] rounds_q, rounds_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             err_q, err_d;
  logic             cnt_clr, cnt_adv, cnt_last;

  round_counter #(.CNT_W(CNT_W)) u_round_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_adv),
    .bound (rounds_q),
    .idx   (round_idx),
    .last  (cnt_last)
  );

  // Next-state, watchdog and error logic; abort overrides every transition.
  always_comb begin
    state_d  = state_q;
    rounds_d = rounds_q;
    wd_d     = wd_q;
    err_d    = err_q;
    cnt_clr  = 1'b0;
    cnt_adv  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          rounds_d = rounds;
          err_d    = 1'b0;
          cnt_clr  = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = (rounds_q == '0) ? S_DONE : S_PREP;
      S_PREP:  state_d = S_KICK;
      S_KICK: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WD_ONE;
        if (rnd_done) begin
          state_d = S_UPDATE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_UPDATE: state_d = S_NEXT;
      S_NEXT: begin
        if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_adv = 1'b1;
          state_d = S_PREP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_d   = err_q;
      cnt_clr = 1'b1;
      cnt_adv = 1'b0;
    end
    out_d = decode_state(state_d);
  end

  // Controller registers; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      rounds_q <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      rounds_q <= rounds_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end

  assign mem_en    = out_q.mem_en;
  assign regs_en   = out_q.regs_en;
  assign f_en      = out_q.f_en;
  assign sel       = out_q.sel;
  assign upd_sel   = out_q.upd_sel;
  assign rnd_start = out_q.rnd_start;
  assign cnt_en    = out_q.cnt_en;
  assign busy      = out_q.busy;
  assign done      = out_q.done;
  assign err       = err_q;

endmodule
